// File: rtl/nios2vga_key_in_pio.sv
//==============================================================================
//  Module   : nios2vga_key_in_pio
//  Purpose  : Avalon-MM key input PIO. Synchronizes WIDTH active-low keys,
//             optionally debounces them, latches falling edges into a
//             write-1-to-clear edgecapture register and raises a level IRQ
//             for every captured edge whose mask bit is set.
//  Ports    : clk        - single clock, rising edge
//             reset      - asynchronous active-high reset
//             address    - word address (0 level, 1 zero, 2 irqmask, 3 edges)
//             chipselect - slave select
//             write_n    - active-low write strobe
//             writedata  - 32-bit write data
//             in_port    - asynchronous keys, idle high
//             readdata   - combinational read data, zero-extended
//             irq        - OR of (edgecapture & irqmask)
//  Config   : define KEY_PIO_DEBOUNCE_EN to enable per-bit debounce of
//             DEBOUNCE_CYCLES stable cycles; otherwise level follows s2.
//             WIDTH must be in the range 1..31.
//  Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nios2vga_key_in_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_level;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecapture;
   logic [WIDTH-1:0] w_fall;
   logic             w_wr;
   logic [31:0]      w_rdata;

   // Upper write-data bits have no destination in this block.
   logic w_unused_wdata;
   assign w_unused_wdata = ^writedata[31:WIDTH];

   // Two-flop synchronizer; resets to the idle (released) key level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= '1;
         r_s2 <= '1;
      end else begin
         r_s1 <= in_port;
         r_s2 <= r_s1;
      end
   end

`ifdef KEY_PIO_DEBOUNCE_EN
   localparam int                  c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0]  c_DB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0]  c_ONE     = c_CNT_W'(1);

   logic [c_CNT_W-1:0] r_cnt [WIDTH];

   // A bit only moves to the synchronized value once it has disagreed with
   // the current level for DEBOUNCE_CYCLES consecutive cycles. Any cycle of
   // agreement restarts the count. The >= compare keeps the counter from
   // ever wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= '1;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (r_s2[i] != r_level[i]) begin
               if (r_cnt[i] >= c_DB_LAST) begin
                  r_level[i] <= r_s2[i];
                  r_cnt[i]   <= '0;
               end else begin
                  r_cnt[i]   <= r_cnt[i] + c_ONE;
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end
`else
   logic w_unused_param;
   assign w_unused_param = (DEBOUNCE_CYCLES == 0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_level <= '1;
      else       r_level <= r_s2;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= '1;
      else       r_prev <= r_level;
   end

   assign w_fall = r_prev & ~r_level;
   assign w_wr   = chipselect & ~write_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqmask     <= '0;
         r_edgecapture <= '0;
      end else begin
         if (w_wr && address == 2'd2)
            r_irqmask <= writedata[WIDTH-1:0];
         // Clear first, then OR in new edges so a same-edge set wins.
         if (w_wr && address == 2'd3)
            r_edgecapture <= (r_edgecapture & ~writedata[WIDTH-1:0]) | w_fall;
         else
            r_edgecapture <= r_edgecapture | w_fall;
      end
   end

   always_comb begin
      w_rdata = '0;
      case (address)
         2'd0:    w_rdata[WIDTH-1:0] = r_level;
         2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
         2'd3:    w_rdata[WIDTH-1:0] = r_edgecapture;
         default: w_rdata = '0;
      endcase
   end

   assign readdata = w_rdata;
   assign irq      = |(r_edgecapture & r_irqmask);

endmodule

`default_nettype wire
